// File: rtl/rv_enc_pkg.sv
// Shared RV32 encoding definitions for the instruction encoder and the control unit.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [6:0]  OPC_R       = 7'b0110011;
    localparam logic [6:0]  OPC_I       = 7'b0010011;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [6:0]  FUNCT7_SUB  = 7'b0100000;
    localparam logic [6:0]  FUNCT7_BASE = 7'b0000000;

    // Micro-op request payload
    typedef struct packed {
        alu_op_e     op;
        logic        fmt;   // 0 = R-type, 1 = I-type
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } uop_t;

    // funct3 field for each ALU operation
    function automatic logic [2:0] funct3_of(input alu_op_e op);
        logic [2:0] f3;
        f3 = 3'b000;
        case (op)
            ALU_ADD, ALU_SUB: f3 = 3'b000;
            ALU_SLL:          f3 = 3'b001;
            ALU_SLT:          f3 = 3'b010;
            ALU_XOR:          f3 = 3'b100;
            ALU_SRL:          f3 = 3'b101;
            ALU_OR:           f3 = 3'b110;
            ALU_AND:          f3 = 3'b111;
            default:          f3 = 3'b000;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packing of micro-op fields into an RV32 R/I-type word.
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  uop_t        uop,
    output logic [31:0] instr_c,
    output logic        illegal_c
);

    logic [2:0] f3;

    assign f3 = funct3_of(uop.op);

    // Select the encoding; I-type SUB has no RV32 form and becomes a NOP
    always_comb begin
        instr_c   = NOP;
        illegal_c = 1'b0;
        if (!uop.fmt) begin
            instr_c = {(uop.op == ALU_SUB) ? FUNCT7_SUB : FUNCT7_BASE,
                       uop.rs2, uop.rs1, f3, uop.rd, OPC_R};
        end else if (uop.op == ALU_SUB) begin
            instr_c   = NOP;
            illegal_c = 1'b1;
        end else if (uop.op == ALU_SLL || uop.op == ALU_SRL) begin
            instr_c = {7'b0000000, uop.imm[4:0], uop.rs1, f3, uop.rd, OPC_I};
        end else begin
            instr_c = {uop.imm, uop.rs1, f3, uop.rd, OPC_I};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32 words with sequential load addresses to the imem loader.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic          in_fmt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [11:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          done,
    output logic [7:0]    err_cnt
);

    localparam logic [0:0]    ST_RUN    = 1'b0;
    localparam logic [0:0]    ST_DONE   = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] addr_cnt;
    logic          last_armed;
    uop_t          uop;
    logic [31:0]   instr_c;
    logic          illegal_c;
    logic          accept;
    logic          out_hs;

    assign uop = '{op: alu_op_e'(in_op), fmt: in_fmt, rd: in_rd,
                   rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    rv_instr_pack u_pack (
        .uop       (uop),
        .instr_c   (instr_c),
        .illegal_c (illegal_c)
    );

    // No accepts during rst/clr, after the last address, or while the output is blocked
    assign in_ready = !rst && !clr && (state == ST_RUN) && !last_armed
                      && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign done     = (state == ST_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Next state: finish once the last word leaves, restart on clr
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (!clr && last_armed && out_hs) state_nxt = ST_DONE;
            ST_DONE: if (clr)                          state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
        if (clr) state_nxt = ST_RUN;
    end

    // Output register, address counter, last flag and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'h0;
            out_addr   <= '0;
            addr_cnt   <= '0;
            last_armed <= 1'b0;
            err_cnt    <= 8'h00;
        end else if (clr) begin
            out_valid  <= 1'b0;
            addr_cnt   <= '0;
            last_armed <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= instr_c;
                out_addr  <= addr_cnt;
                if (addr_cnt == LAST_ADDR) begin
                    addr_cnt   <= '0;
                    last_armed <= 1'b1;
                end else begin
                    addr_cnt <= addr_cnt + AW'(1);
                end
                if (illegal_c && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4).
module tb_instr_encoder;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = 3'd0;
    logic          in_fmt = 1'b0;
    logic [4:0]    in_rd = 5'd0;
    logic [4:0]    in_rs1 = 5'd0;
    logic [4:0]    in_rs2 = 5'd0;
    logic [11:0]   in_imm = 12'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          done;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .done      (done),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] op, input logic fmt, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        in_op  = op;
        in_fmt = fmt;
        in_rd  = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_imm = imm;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=00000000", out_instr); end
        total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", out_addr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_r_add();
        out_ready = 1'b1;
        set_req(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
        total++; if (out_instr !== 32'h002081B3) begin bad++; $display("FAIL add_instr got=%h want=002081b3", out_instr); end
        total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL add_addr got=%0d want=0", out_addr); end
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", out_valid); end
        pulse_clr();
    endtask

    task automatic test_sub_iadd();
        set_req(3'b001, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
        in_valid = 1'b1;
        cyc();
        total++; if (out_instr !== 32'h407302B3) begin bad++; $display("FAIL sub_instr got=%h want=407302b3", out_instr); end
        total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL sub_addr got=%0d want=0", out_addr); end
        set_req(3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF);
        cyc();
        in_valid = 1'b0;
        total++; if (out_instr !== 32'hFFF00093) begin bad++; $display("FAIL iadd_instr got=%h want=fff00093", out_instr); end
        total++; if (out_addr !== 4'd1) begin bad++; $display("FAIL iadd_addr got=%0d want=1", out_addr); end
    endtask

    task automatic test_illegal_shift();
        set_req(3'b001, 1'b1, 5'd2, 5'd2, 5'd0, 12'h123);
        in_valid = 1'b1;
        cyc();
        total++; if (out_instr !== 32'h00000013) begin bad++; $display("FAIL isub_instr got=%h want=00000013", out_instr); end
        total++; if (out_addr !== 4'd2) begin bad++; $display("FAIL isub_addr got=%0d want=2", out_addr); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL isub_err got=%0d want=1", err_cnt); end
        set_req(3'b101, 1'b1, 5'd4, 5'd5, 5'd0, 12'hFE3);
        cyc();
        in_valid = 1'b0;
        total++; if (out_instr !== 32'h00329213) begin bad++; $display("FAIL slli_instr got=%h want=00329213", out_instr); end
        total++; if (out_addr !== 4'd3) begin bad++; $display("FAIL slli_addr got=%0d want=3", out_addr); end
        cyc();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL slli_done got=%b want=1", done); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL slli_err_hold got=%0d want=1", err_cnt); end
        pulse_clr();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL clr_done got=%b want=0", done); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_req(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
        in_valid = 1'b1;
        cyc();
        set_req(3'b011, 1'b0, 5'd7, 5'd8, 5'd9, 12'd0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (out_valid !== 1'b1 || out_instr !== 32'h003100B3 || out_addr !== 4'd0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%h/%0d/%b want=1/003100b3/0/0", i, out_valid, out_instr, out_addr, in_ready);
            end
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_instr !== 32'h009463B3) begin bad++; $display("FAIL stall_next_instr got=%h want=009463b3", out_instr); end
        total++; if (out_addr !== 4'd1) begin bad++; $display("FAIL stall_next_addr got=%0d want=1", out_addr); end
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", out_valid); end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0000F093;
        exp_w[1] = 32'h0010F093;
        exp_w[2] = 32'h0020F093;
        exp_w[3] = 32'h0030F093;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(3'b010, 1'b1, 5'd1, 5'd1, 5'd0, 12'(i));
            in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, in_ready); end
            cyc();
            total++; if (out_valid !== 1'b1 || out_addr !== 4'(i) || out_instr !== exp_w[i]) begin
                bad++;
                $display("FAIL b2b_word%0d got=%b/%0d/%h want=1/%0d/%h", i, out_valid, out_addr, out_instr, i, exp_w[i]);
            end
        end
        set_req(3'b000, 1'b0, 5'd9, 5'd9, 5'd9, 12'd0);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_fifth_ready got=%b want=0", in_ready); end
        cyc();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_fifth_valid got=%b want=0", out_valid); end
        cyc();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_blocked got=%b/%b want=0/0", out_valid, in_ready); end
        in_valid = 1'b0;
        pulse_clr();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_clr_done got=%b want=0", done); end
        set_req(3'b111, 1'b0, 5'd2, 5'd3, 5'd4, 12'd0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL b2b_restart_addr got=%0d want=0", out_addr); end
        total++; if (out_instr !== 32'h0041A133) begin bad++; $display("FAIL b2b_slt_instr got=%h want=0041a133", out_instr); end
        cyc();
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        set_req(3'b001, 1'b1, 5'd2, 5'd2, 5'd0, 12'd0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("FAIL rst_pre got=%b/%0d want=1/1", out_valid, err_cnt); end
        rst = 1'b1;
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", out_addr); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=00000000", out_instr); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_cnt); end
        rst = 1'b0;
        out_ready = 1'b1;
        set_req(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_instr !== 32'h002081B3 || out_addr !== 4'd0) begin bad++; $display("FAIL rst_restart got=%h/%0d want=002081b3/0", out_instr, out_addr); end
        cyc();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_r_add();
        test_sub_iadd();
        test_illegal_shift();
        test_stall();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
